// File: rtl/qix_input_pkg.sv
// Shared types and helpers for the Qix input conditioning stage.
// Latency: n/a (package: constants, enums and pure functions only).
// Backpressure: n/a.
package qix_input_pkg;

    // Bit positions inside a {R,L,D,U} direction nibble
    localparam int DIR_U = 0;
    localparam int DIR_D = 1;
    localparam int DIR_L = 2;
    localparam int DIR_R = 3;

    // Default timing: 1 ms tick at 20 MHz, 3 ms debounce, 50 ms coin pulse
    localparam int unsigned TICK_DIV_DEF       = 20000;
    localparam int unsigned DEBOUNCE_TICKS_DEF = 3;
    localparam int unsigned COIN_TICKS_DEF     = 50;

    typedef enum logic [1:0] {
        COIN_IDLE     = 2'd0,
        COIN_PULSE    = 2'd1,
        COIN_WAIT_REL = 2'd2
    } coin_state_t;

    typedef enum logic [2:0] {
        FW_NEUTRAL = 3'd0,
        FW_HOLD_U  = 3'd1,
        FW_HOLD_D  = 3'd2,
        FW_HOLD_L  = 3'd3,
        FW_HOLD_R  = 3'd4
    } fw_state_t;

    // Opposing directions cancel each other out
    function automatic logic [3:0] clean_dirs(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[DIR_U] && d[DIR_D]) begin
            r[DIR_U] = 1'b0;
            r[DIR_D] = 1'b0;
        end
        if (d[DIR_L] && d[DIR_R]) begin
            r[DIR_L] = 1'b0;
            r[DIR_R] = 1'b0;
        end
        return r;
    endfunction

    // Highest-priority pressed direction, U > D > L > R
    function automatic fw_state_t fw_pick(input logic [3:0] d);
        fw_state_t s;
        s = FW_NEUTRAL;
        if (d[DIR_U])      s = FW_HOLD_U;
        else if (d[DIR_D]) s = FW_HOLD_D;
        else if (d[DIR_L]) s = FW_HOLD_L;
        else if (d[DIR_R]) s = FW_HOLD_R;
        return s;
    endfunction

    // One-hot direction set asserted by a 4-way state
    function automatic logic [3:0] fw_dirs(input fw_state_t s);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            FW_HOLD_U: r[DIR_U] = 1'b1;
            FW_HOLD_D: r[DIR_D] = 1'b1;
            FW_HOLD_L: r[DIR_L] = 1'b1;
            FW_HOLD_R: r[DIR_R] = 1'b1;
            default:   r = 4'b0000;
        endcase
        return r;
    endfunction

    // Keep the held direction while it stays pressed, otherwise re-pick
    function automatic fw_state_t fw_next(input fw_state_t s, input logic [3:0] d);
        if ((fw_dirs(s) & d) != 4'b0000) return s;
        return fw_pick(d);
    endfunction

endpackage

// File: rtl/qix_debounce.sv
// One-bit debouncer: output follows input after DEBOUNCE_TICKS consecutive agreeing tick samples.
// Latency: DEBOUNCE_TICKS ticks from a stable input change to dout.
// Backpressure: none; samples only when tick is high.
module qix_debounce
    import qix_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk_20m,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic dout
);

    logic       stable;
    logic [3:0] cnt;

    // Count consecutive disagreeing samples; adopt the sample once the run is long enough
    always_ff @(posedge clk_20m) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= 4'd0;
        end else if (tick) begin
            if (din == stable) begin
                cnt <= 4'd0;
            end else if (cnt == 4'(DEBOUNCE_TICKS - 1)) begin
                stable <= din;
                cnt    <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/qix_input_cond.sv
// Debounces raw MiSTer controls into active-low Qix inputs; define QIX_INPUT_4WAY_EN for a 4-way joystick filter.
// Latency: DEBOUNCE_TICKS ticks + 1 cycle from raw press to output; coin pulse is COIN_TICKS*TICK_DIV cycles wide.
// Backpressure: none; all outputs are registered level signals updated every cycle.
module qix_input_cond
    import qix_input_pkg::*;
#(
    parameter int unsigned TICK_DIV       = TICK_DIV_DEF,
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int unsigned COIN_TICKS     = COIN_TICKS_DEF
) (
    input  logic       clk_20m,
    input  logic       reset,
    input  logic [1:0] coin_raw,
    input  logic [1:0] start_raw,
    input  logic [3:0] p1_dir_raw,
    input  logic [3:0] p2_dir_raw,
    input  logic       p1_fire_raw,
    input  logic       p2_fire_raw,
    output logic [1:0] coin,
    output logic [1:0] start_buttons,
    output logic [3:0] p1_joystick,
    output logic [3:0] p2_joystick,
    output logic       p1_fire,
    output logic       p2_fire
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Free-running tick divider
    always_ff @(posedge clk_20m) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // Raw bits gathered so all 14 debouncers come from one generate loop
    logic [13:0] raw_all;
    logic [13:0] deb_all;

    assign raw_all = {p2_fire_raw, p1_fire_raw, p2_dir_raw, p1_dir_raw, start_raw, coin_raw};

    for (genvar g = 0; g < 14; g++) begin : g_deb
        qix_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_deb (
            .clk_20m(clk_20m),
            .reset  (reset),
            .tick   (tick),
            .din    (raw_all[g]),
            .dout   (deb_all[g])
        );
    end

    logic [1:0] deb_coin;
    logic [3:0] clean_p1;
    logic [3:0] clean_p2;

    assign deb_coin = deb_all[1:0];
    assign clean_p1 = clean_dirs(deb_all[7:4]);
    assign clean_p2 = clean_dirs(deb_all[11:8]);

    // Coin pulse shapers: one fixed-width pulse per debounced press
    logic [1:0] pulse_nx;

    for (genvar g = 0; g < 2; g++) begin : g_coin
        coin_state_t st;
        coin_state_t st_nx;
        logic [7:0]  cnt;
        logic [7:0]  cnt_nx;

        // Next-state: start on press, count ticks down, then wait for release
        always_comb begin
            st_nx  = st;
            cnt_nx = cnt;
            case (st)
                COIN_IDLE: begin
                    if (deb_coin[g]) begin
                        st_nx  = COIN_PULSE;
                        cnt_nx = 8'(COIN_TICKS);
                    end
                end
                COIN_PULSE: begin
                    // Exit one cycle after the last tick so width is exactly COIN_TICKS*TICK_DIV
                    if (cnt == 8'd0)  st_nx  = COIN_WAIT_REL;
                    else if (tick)    cnt_nx = cnt - 8'd1;
                end
                COIN_WAIT_REL: begin
                    if (!deb_coin[g]) st_nx = COIN_IDLE;
                end
                default: begin
                    st_nx  = COIN_IDLE;
                    cnt_nx = 8'd0;
                end
            endcase
        end

        // Coin FSM state register
        always_ff @(posedge clk_20m) begin
            if (reset) begin
                st  <= COIN_IDLE;
                cnt <= 8'd0;
            end else begin
                st  <= st_nx;
                cnt <= cnt_nx;
            end
        end

        assign pulse_nx[g] = (st_nx == COIN_PULSE);
    end

    logic [3:0] joy_p1;
    logic [3:0] joy_p2;

`ifdef QIX_INPUT_4WAY_EN
    // Step one cycle after tick so the filter sees the freshly debounced set
    logic      tick_d;
    fw_state_t fw_p1;
    fw_state_t fw_p2;
    fw_state_t fw_p1_nx;
    fw_state_t fw_p2_nx;

    // 4-way next-state, advanced once per tick
    always_comb begin
        fw_p1_nx = fw_p1;
        fw_p2_nx = fw_p2;
        if (tick_d) begin
            fw_p1_nx = fw_next(fw_p1, clean_p1);
            fw_p2_nx = fw_next(fw_p2, clean_p2);
        end
    end

    // 4-way state register
    always_ff @(posedge clk_20m) begin
        if (reset) begin
            tick_d <= 1'b0;
            fw_p1  <= FW_NEUTRAL;
            fw_p2  <= FW_NEUTRAL;
        end else begin
            tick_d <= tick;
            fw_p1  <= fw_p1_nx;
            fw_p2  <= fw_p2_nx;
        end
    end

    assign joy_p1 = fw_dirs(fw_p1_nx);
    assign joy_p2 = fw_dirs(fw_p2_nx);
`else
    assign joy_p1 = clean_p1;
    assign joy_p2 = clean_p2;
`endif

    // Registered active-low outputs, all released in reset
    always_ff @(posedge clk_20m) begin
        if (reset) begin
            coin          <= 2'b11;
            start_buttons <= 2'b11;
            p1_joystick   <= 4'b1111;
            p2_joystick   <= 4'b1111;
            p1_fire       <= 1'b1;
            p2_fire       <= 1'b1;
        end else begin
            coin          <= ~pulse_nx;
            start_buttons <= ~deb_all[3:2];
            p1_joystick   <= ~joy_p1;
            p2_joystick   <= ~joy_p2;
            p1_fire       <= ~deb_all[12];
            p2_fire       <= ~deb_all[13];
        end
    end

endmodule

// File: tb/tb_qix_input_cond.sv
// Bench for qix_input_cond: reference model pushes expected output changes, monitor pops and checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_qix_input_cond;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int CT = 5;

    logic       clk_20m = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin_raw = 2'b00;
    logic [1:0] start_raw = 2'b00;
    logic [3:0] p1_dir_raw = 4'b0000;
    logic [3:0] p2_dir_raw = 4'b0000;
    logic       p1_fire_raw = 1'b0;
    logic       p2_fire_raw = 1'b0;
    logic [1:0] coin;
    logic [1:0] start_buttons;
    logic [3:0] p1_joystick;
    logic [3:0] p2_joystick;
    logic       p1_fire;
    logic       p2_fire;

    qix_input_cond #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DB),
        .COIN_TICKS    (CT)
    ) dut (
        .clk_20m      (clk_20m),
        .reset        (reset),
        .coin_raw     (coin_raw),
        .start_raw    (start_raw),
        .p1_dir_raw   (p1_dir_raw),
        .p2_dir_raw   (p2_dir_raw),
        .p1_fire_raw  (p1_fire_raw),
        .p2_fire_raw  (p2_fire_raw),
        .coin         (coin),
        .start_buttons(start_buttons),
        .p1_joystick  (p1_joystick),
        .p2_joystick  (p2_joystick),
        .p1_fire      (p1_fire),
        .p2_fire      (p2_fire)
    );

    always #5 clk_20m = ~clk_20m;

    typedef struct {
        int          cyc;
        logic [13:0] val;
    } ev_t;

    ev_t         evq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [13:0] last_seen = '1;
    logic [13:0] prev_exp = '1;

    // Reference model state (timestamps and run lengths, not register images)
    int          tcnt = 0;
    logic [13:0] st = '0;
    int          run[14];
    bit          busy[2];
    bit          waitrel[2];
    int          pend[2];
    int          held[2];
    bit          tick_d = 1'b0;

    function automatic logic [3:0] m_clean(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[0] && d[1]) begin r[0] = 1'b0; r[1] = 1'b0; end
        if (d[2] && d[3]) begin r[2] = 1'b0; r[3] = 1'b0; end
        return r;
    endfunction

    function automatic int pick(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return -1;
    endfunction

    function automatic int hold_next(input int h, input logic [3:0] c);
        if (h >= 0 && c[h]) return h;
        return pick(c);
    endfunction

    function automatic logic [3:0] onehot(input int h);
        logic [3:0] r;
        r = 4'b0000;
        if (h >= 0) r[h] = 1'b1;
        return r;
    endfunction

    function automatic logic [13:0] dut_vec();
        return {coin, start_buttons, p1_joystick, p2_joystick, p1_fire, p2_fire};
    endfunction

    // Reference model: evaluates what the outputs must be after each rising edge
    always @(posedge clk_20m) begin
        logic [13:0] rv;
        logic [13:0] old;
        logic [13:0] expv;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic [3:0]  j1;
        logic [3:0]  j2;
        bit          tk;
        ev_t         e;
        cyc++;
        rv = {p2_fire_raw, p1_fire_raw, p2_dir_raw, p1_dir_raw, start_raw, coin_raw};
        if (reset) begin
            tcnt = 0;
            st = '0;
            for (int i = 0; i < 14; i++) run[i] = 0;
            for (int i = 0; i < 2; i++) begin
                busy[i] = 1'b0; waitrel[i] = 1'b0; pend[i] = 0; held[i] = -1;
            end
            tick_d = 1'b0;
            expv = '1;
        end else begin
            old = st;
            tk = (tcnt == TD - 1);
            tcnt = tk ? 0 : tcnt + 1;
            for (int i = 0; i < 2; i++) begin
                if (waitrel[i]) begin
                    if (!old[i]) waitrel[i] = 1'b0;
                end else if (busy[i]) begin
                    if (cyc == pend[i]) begin busy[i] = 1'b0; waitrel[i] = 1'b1; end
                end else if (old[i]) begin
                    busy[i] = 1'b1;
                    pend[i] = cyc + CT * TD;
                end
            end
            if (tk) begin
                for (int i = 0; i < 14; i++) begin
                    if (rv[i] == st[i]) run[i] = 0;
                    else begin
                        run[i]++;
                        if (run[i] == DB) begin st[i] = rv[i]; run[i] = 0; end
                    end
                end
            end
            c1 = m_clean(old[7:4]);
            c2 = m_clean(old[11:8]);
`ifdef QIX_INPUT_4WAY_EN
            if (tick_d) begin
                held[0] = hold_next(held[0], c1);
                held[1] = hold_next(held[1], c2);
            end
            j1 = onehot(held[0]);
            j2 = onehot(held[1]);
`else
            j1 = c1;
            j2 = c2;
`endif
            tick_d = tk;
            expv = {~busy[1], ~busy[0], ~old[3:2], ~j1, ~j2, ~old[12], ~old[13]};
        end
        if (expv !== prev_exp) begin
            e.cyc = cyc;
            e.val = expv;
            evq.push_back(e);
            prev_exp = expv;
        end
    end

    // Monitor: every observed output change must match the next expected change
    always @(negedge clk_20m) begin
        logic [13:0] cur;
        ev_t         e;
        if (mon_en) begin
            cur = dut_vec();
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                total++; bad++;
                $display("FAIL missed_change cyc=%0d: outputs stayed %b, required %b", e.cyc, cur, e.val);
            end
            if (cur !== last_seen) begin
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d: got %b, required %b", cyc, cur, last_seen);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        bad++;
                        $display("FAIL output_change: got %b at cyc %0d, required %b at cyc %0d",
                                 cur, cyc, e.val, e.cyc);
                    end
                end
                last_seen = cur;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_20m);
    endtask

    task automatic set_raw(input logic [13:0] v);
        coin_raw    = v[1:0];
        start_raw   = v[3:2];
        p1_dir_raw  = v[7:4];
        p2_dir_raw  = v[11:8];
        p1_fire_raw = v[12];
        p2_fire_raw = v[13];
    endtask

    // Wait (bounded) for coin[idx] to go low
    task automatic wait_coin_low(input int idx, input string name, output bit ok);
        int t;
        t = 0;
        while (coin[idx] !== 1'b0 && t < 100) begin @(negedge clk_20m); t++; end
        ok = (t < 100);
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: coin[%0d] still %b, required 0", name, idx, coin[idx]);
        end
    endtask

    task automatic measure_low(input int idx, input string name);
        int w;
        bit ok;
        wait_coin_low(idx, name, ok);
        if (ok) begin
            w = 0;
            while (coin[idx] === 1'b0 && w < 200) begin @(negedge clk_20m); w++; end
            chk(name, w, CT * TD);
        end
    endtask

    initial begin
        int          lat;
        int          lows;
        int          w;
        bit          ok;
        logic [13:0] rv;
        logic [3:0]  exp_j;

        set_raw('0);
        reset = 1'b1;
        cycles(3);
        chk("reset_state", int'(dut_vec()), 16'h3fff);
        last_seen = '1;
        mon_en = 1'b1;
        reset = 1'b0;
        cycles(5);

        // Debounce latency and glitch rejection
        p1_fire_raw = 1'b1;
        lat = 0;
        while (p1_fire !== 1'b0 && lat < 50) begin @(negedge clk_20m); lat++; end
        chk("fire_latency_min", int'(lat >= 2 * TD + 2), 1);
        chk("fire_latency_max", int'(lat <= 3 * TD + 1), 1);
        cycles(5);
        p2_fire_raw = 1'b1;
        cycles(2 * TD);
        p2_fire_raw = 1'b0;
        cycles(20);
        chk("fire_glitch", int'(p2_fire), 1);
        p1_fire_raw = 1'b0;
        cycles(20);

        // Single coin pulse while held, then a second after re-press
        coin_raw[0] = 1'b1;
        measure_low(0, "coin_width1");
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_20m);
            if (coin[0] === 1'b0) lows++;
        end
        chk("coin_held_once", lows, 0);
        coin_raw[0] = 1'b0;
        cycles(40);
        coin_raw[0] = 1'b1;
        measure_low(0, "coin_width2");
        cycles(20);
        coin_raw[0] = 1'b0;
        cycles(40);

        // Opposing directions
        p1_dir_raw = 4'b0011;
        cycles(30);
        chk("joy_ud_cancel", int'(p1_joystick), 4'b1111);
        p1_dir_raw = 4'b0101;
        cycles(30);
`ifdef QIX_INPUT_4WAY_EN
        exp_j = 4'b1110;
`else
        exp_j = 4'b1010;
`endif
        chk("joy_diag", int'(p1_joystick), int'(exp_j));
        p1_dir_raw = 4'b0000;
        cycles(30);

        // Hold behaviour: L then L+U, release L, release all
        p1_dir_raw = 4'b0100;
        cycles(30);
        p1_dir_raw = 4'b0101;
        cycles(30);
`ifdef QIX_INPUT_4WAY_EN
        exp_j = 4'b1011;
`else
        exp_j = 4'b1010;
`endif
        chk("joy_hold", int'(p1_joystick), int'(exp_j));
        p1_dir_raw = 4'b0001;
        cycles(30);
        chk("joy_up_only", int'(p1_joystick), 4'b1110);
        p1_dir_raw = 4'b0000;
        cycles(30);
        chk("joy_release", int'(p1_joystick), 4'b1111);

        // Reset in the middle of a coin pulse
        coin_raw[0] = 1'b1;
        wait_coin_low(0, "coin_pre_reset", ok);
        cycles(8);
        reset = 1'b1;
        @(negedge clk_20m);
        chk("reset_mid_pulse", int'(dut_vec()), 16'h3fff);
        reset = 1'b0;
        measure_low(0, "coin_after_reset");
        coin_raw[0] = 1'b0;
        cycles(40);

        // Both coins together
        coin_raw = 2'b11;
        w = 0;
        while (coin === 2'b11 && w < 100) begin @(negedge clk_20m); w++; end
        chk("coin_both_start", int'(coin), 0);
        w = 0;
        while (coin === 2'b00 && w < 200) begin @(negedge clk_20m); w++; end
        chk("coin_both_width", w, CT * TD);
        chk("coin_both_end", int'(coin), 3);
        coin_raw = 2'b00;
        cycles(40);

        // Randomized activity on every input, with occasional resets
        rv = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_20m);
            if ($urandom_range(0, 5) == 0) begin
                int idx;
                idx = $urandom_range(0, 13);
                rv[idx] = ~rv[idx];
                set_raw(rv);
            end
            reset = ($urandom_range(0, 1499) == 0);
        end
        reset = 1'b0;
        set_raw('0);
        cycles(200);

        chk("pending_events", evq.size(), 0);
        chk("final_outputs", int'(dut_vec()), 16'h3fff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qix_input_cond.md
# qix_input_cond

Input conditioning stage directly upstream of the Qix platform top. Takes raw active-high control bits from the MiSTer framework and produces the debounced, active-low `coin`, `start_buttons`, `p1_joystick`, `p2_joystick`, `p1_fire` and `p2_fire` signals that Qix assembles into the PIA input bytes. Per-bit debouncing, opposing-direction cleaning, optional 4-way joystick restriction and fixed-width coin pulses are all paced by an internal millisecond tick.

## Interface
- `TICK_DIV`, 20000: `clk_20m` cycles per tick (1 ms at 20 MHz).
- `DEBOUNCE_TICKS`, 3: consecutive identical samples required before a debounced bit changes (range 1–15).
- `COIN_TICKS`, 50: coin output low-pulse width in ticks (range 1–255).

- `clk_20m` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `coin_raw` in 2: coin switches, active-high, {coin2, coin1}.
- `start_raw` in 2: start buttons, active-high, {start2, start1}.
- `p1_dir_raw` in 4: P1 {R,L,D,U}, active-high.
- `p2_dir_raw` in 4: P2 {R,L,D,U}, active-high.
- `p1_fire_raw`, `p2_fire_raw` in 1: fire buttons, active-high.
- `coin` out 2: active-low coin pulses to Qix.
- `start_buttons` out 2: active-low.
- `p1_joystick`, `p2_joystick` out 4: active-low {R,L,D,U}.
- `p1_fire`, `p2_fire` out 1: active-low.

## Operation
- **Tick generator:** a counter runs 0..TICK_DIV-1. It asserts a one-cycle internal `tick` when the counter equals TICK_DIV-1, then wraps to 0.
- **Debounce (14 instances: 2 coin, 2 start, 8 dir, 2 fire):**
  - Sampling happens only on `tick`.
  - If the sample equals the stable state, the count clears.
  - Otherwise the count increments. When it reaches DEBOUNCE_TICKS, the stable state takes the sample and the count clears.
  - A glitch shorter than DEBOUNCE_TICKS ticks never propagates.
- **Opposite cleaning (always on, per player):** debounced U and D both set → both cleared. L and R handled the same way.
- **Coin pulse (per coin):**
  - States: IDLE, PULSE, WAIT_REL.
  - IDLE → PULSE on a debounced rising edge; the pulse counter loads COIN_TICKS.
  - PULSE decrements on `tick`. At 0 → WAIT_REL.
  - WAIT_REL → IDLE when the debounced coin reads 0.
  - The coin output is low only in PULSE. Holding the switch yields exactly one pulse.
  - A release and re-press during PULSE does not extend or restart the pulse.
- **Start/fire:** debounced value, inverted.
- **Joystick output:** cleaned direction set, passed through the optional 4-way filter, then inverted.

## Timing
- **Reset:**
  - All outputs 1 (released).
  - Tick counter 0.
  - Debounce stable states 0, counts 0.
  - Coin FSMs IDLE.
  - 4-way state NEUTRAL.
- **Reset mid-pulse:** aborts the pulse. `coin` returns high the cycle after `reset` is sampled.
- **Output timing:** all outputs are registered and update one cycle after the `tick` cycle that changed the debounced state.
  - Press-to-output latency: DEBOUNCE_TICKS ticks + 1 cycle.
  - Coin low width: exactly COIN_TICKS × TICK_DIV cycles ± 0.
- **Simultaneous events:**
  - Both coins pressed on the same tick → two independent pulses.
  - Opposing directions debounced on the same tick → neither is asserted.

## Configuration
- **`QIX_INPUT_4WAY_EN` defined:** per-player FSM with states NEUTRAL and HOLD(dir).
  - NEUTRAL with any direction pressed → HOLD of the highest-priority pressed direction (U>D>L>R).
  - HOLD(d) with d still pressed → stays in HOLD(d), even if others are added.
  - HOLD(d) with d released and others pressed → HOLD of the highest-priority remaining direction.
  - HOLD with none pressed → NEUTRAL.
  - Output has at most one direction asserted.
  - The FSM updates only on `tick`.
- **`QIX_INPUT_4WAY_EN` undefined:** the cleaned set passes straight through, so diagonals are allowed. No FSM is synthesised.

## Structure
- **`qix_input_pkg`:**
  - Direction index constants DIR_U=0, DIR_D=1, DIR_L=2, DIR_R=3.
  - Coin FSM state enum.
  - 4-way state enum.
  - Default constants for TICK_DIV, DEBOUNCE_TICKS, COIN_TICKS.
- **Sub-module `qix_debounce`:** one bit, with ports `clk_20m`, `reset`, `tick`, `din`, `dout`; parameter DEBOUNCE_TICKS. Instantiated 14 times.
- Tick counter, coin FSMs and the 4-way filter live in the top.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, COIN_TICKS=5.
1. **Debounce and latency:** hold `p1_fire_raw`=1 → `p1_fire` goes 0 at 3 ticks + 1 cycle (~13 cycles). A 2-tick pulse on `p2_fire_raw` → `p2_fire` stays 1.
2. **Single coin pulse:** hold `coin_raw[0]`=1 for 100 ticks → `coin[0]` low for exactly 20 cycles, once. Release, re-press → a second 20-cycle pulse.
3. **Opposing directions:** `p1_dir_raw`=4'b0011 (U+D) → `p1_joystick`=4'b1111. `p1_dir_raw`=4'b0101 → 4'b1010 with 4-way off; with `QIX_INPUT_4WAY_EN` the result is 4'b1110 (U only).
4. **4-way hold (`QIX_INPUT_4WAY_EN`):** press L (4'b0100), then add U (4'b0101) → output stays L (4'b1011). Release L → output U (4'b1110). Release all → 4'b1111.
5. **Reset mid-pulse:** assert `reset` 8 cycles into a coin pulse → all outputs 1 the next cycle. Raw coin still held after reset → new pulse after debounce, 20 cycles wide.
6. **Simultaneous coins:** `coin_raw`=2'b11 on one cycle → both `coin` bits low over an identical 20-cycle window.
